seq_detect_scheduler: RTL and testbench
=======================================

# seq_detect_scheduler

Round-robin scheduler that shares one serial 1100 Moore sequence detector (non-overlapping) among N_REQ requesters. Each requester submits a W-bit word. The block grants one requester at a time, resets the detector, and shifts the word in MSB-first. It then returns the number of detected 1100 patterns, tagged with the requester index.

## Interface
- N_REQ, 4: number of requesters (2..8).
- W, 8: word width in bits, serialized MSB-first (≥4).
- CNT_W, 4: hit-count width; the count saturates at 2^CNT_W-1.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  level request per requester; held until its gnt bit pulses.
- req_data  in  N_REQ*W  packed words; requester i occupies [i*W +: W] and holds it stable while req[i]=1.
- gnt  out  N_REQ  one-hot, one-cycle grant pulse; req_data[i] is captured in the same cycle.
- busy  out  1  high from LOAD through DONE.
- done  out  1  one-cycle result-valid pulse.
- done_id  out  $clog2(N_REQ)  index of the finished requester; valid while done=1.
- hit_cnt  out  CNT_W  1100 matches found in the word; valid while done=1.

## Operation
- FSM states and transitions:
  - IDLE → LOAD when any req is high.
  - LOAD → SHIFT.
  - SHIFT → DRAIN after W bits.
  - DRAIN → DONE.
  - DONE → IDLE.
- Arbitration happens in IDLE only. The search starts at last_grant+1 and wraps modulo N_REQ. The first asserted req wins.
- LOAD:
  - gnt[winner]=1.
  - Shift register ← req_data word.
  - last_grant ← winner.
  - Bit counter ← 0, hit counter ← 0.
  - Detector reset is driven high.
- SHIFT: the detector input is shreg[W-1], the shift register shifts left each cycle, and the bit counter increments. Exit when the counter reaches W-1.
- DRAIN: the detector input is driven 0. This cycle exists only to observe Y produced by the final bit.
- Hit counting: hit counter += Y on every cycle in SHIFT or DRAIN. It saturates and never wraps.
- DONE: done=1, done_id=last_grant, hit_cnt=hit counter. Outputs are zero when done=0.
- Requests during a job are ignored until IDLE. A req that drops mid-job does not abort the job.
- A requester that keeps req high after its gnt is a new request and is re-served in round-robin turn.
- Detector semantics are non-overlapping 1100: after a detect, matching restarts with no carried-over bits.

## Timing
- Reset values:
  - State=IDLE, last_grant=N_REQ-1, so requester 0 has first priority.
  - gnt=0, busy=0, done=0, done_id=0, hit_cnt=0.
  - The detector is reset.
- Latency: gnt in cycle T, bits presented T+1..T+W, DRAIN at T+W+1, done at T+W+2.
- Back-to-back jobs: the next gnt comes no earlier than T+W+4. This gives a throughput of one job per W+4 cycles.
- Reset asserted mid-job:
  - The job is abandoned and no done pulse is produced.
  - The next cycle is IDLE with all reset values.
  - The requester must re-request.
- Reset takes priority over every other event.

## Configuration
- SEQ_SCHED_STATS_EN defined:
  - Adds output total_hits (16 bits).
  - In DONE it accumulates hit_cnt, saturating at 16'hFFFF.
  - Cleared only by rst.
- SEQ_SCHED_STATS_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package seq_sched_pkg holds:
  - The FSM state encoding (IDLE, LOAD, SHIFT, DRAIN, DONE).
  - The detector state encoding (S0..S4).
  - Default constants N_REQ_DEF=4, W_DEF=8, CNT_W_DEF=4.
- One sub-module, seq1100_det (ports clk, rst, in_bit, Y):
  - Moore, non-overlapping.
  - Y=1 only in S4.
  - Its rst is driven by (rst | load).

## Test plan
- Reset, then req=4'b0001, word0=8'b1100_1100 → gnt=0001 at T, done at T+10, done_id=0, hit_cnt=2.
- Word 8'b1110_0110 → hit_cnt=1. Word 8'hFF → hit_cnt=0. Word 8'h00 → hit_cnt=0.
- req=4'b1111 held from reset, words all 8'hCC → grants in order 0,1,2,3, spaced 12 cycles apart, each with hit_cnt=2.
- With last_grant=2 and req=4'b0101 → next grant goes to 0, not 2.
- rst pulsed during SHIFT of a job → no done, busy=0 next cycle; the re-request then yields a correct result.
- Stats enabled: three jobs with hits 2, 1, 2 → total_hits=5. Stats disabled: the build has no total_hits port.

Source files
------------

// File: rtl/seq_detect_scheduler_pkg.sv
// Shared encodings and default sizes for the round-robin 1100 detector scheduler.
package seq_sched_pkg;

   localparam int unsigned N_REQ_DEF = 4;
   localparam int unsigned W_DEF     = 8;
   localparam int unsigned CNT_W_DEF = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      SHIFT = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } sched_state_e;

   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4
   } det_state_e;

endpackage

// File: rtl/seq_detect_scheduler_det.sv
// Moore non-overlapping serial 1100 detector; Y is high only in S4.
module seq1100_det
   import seq_sched_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic in_bit,
   output logic Y
);

   det_state_e state_q, state_d;
   logic       y_q, y_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S0;
         y_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
      end
   end

   // After a detect (S4) matching restarts from scratch.
   always_comb begin
      state_d = S0;
      case (state_q)
         S0:      state_d = in_bit ? S1 : S0;
         S1:      state_d = in_bit ? S2 : S0;
         S2:      state_d = in_bit ? S2 : S3;
         S3:      state_d = in_bit ? S1 : S4;
         S4:      state_d = in_bit ? S1 : S0;
         default: state_d = S0;
      endcase
      y_d = (state_d == S4);
   end

   assign Y = y_q;

endmodule

// File: rtl/seq_detect_scheduler.sv
// Round-robin scheduler sharing one 1100 detector among N_REQ requesters.
// Optional SEQ_SCHED_STATS_EN adds a saturating total_hits accumulator.
module seq_detect_scheduler
   import seq_sched_pkg::*;
#(
   parameter int unsigned N_REQ = N_REQ_DEF,
   parameter int unsigned W     = W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*W-1:0]       req_data,
   output logic [N_REQ-1:0]         gnt,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(N_REQ)-1:0] done_id,
   output logic [CNT_W-1:0]         hit_cnt
`ifdef SEQ_SCHED_STATS_EN
   ,
   output logic [15:0]              total_hits
`endif
);

   localparam int unsigned ID_W  = $clog2(N_REQ);
   localparam int unsigned BIT_W = $clog2(W);

   sched_state_e      state_q, state_d;
   logic [ID_W-1:0]   last_grant_q, last_grant_d;
   logic [W-1:0]      shreg_q, shreg_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0]  hits_q, hits_d;
   logic [N_REQ-1:0]  gnt_q, gnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [ID_W-1:0]   done_id_q, done_id_d;
   logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;

   logic              found_c;
   logic [ID_W-1:0]   winner_c, cand_c;
   logic [W-1:0]      load_word_c;
   logic [CNT_W-1:0]  hits_inc_c;
   logic              det_in_c, det_rst_c, det_y_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= ID_W'(N_REQ - 1);
         shreg_q      <= '0;
         bit_cnt_q    <= '0;
         hits_q       <= '0;
         gnt_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         done_id_q    <= '0;
         hit_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         shreg_q      <= shreg_d;
         bit_cnt_q    <= bit_cnt_d;
         hits_q       <= hits_d;
         gnt_q        <= gnt_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         done_id_q    <= done_id_d;
         hit_cnt_q    <= hit_cnt_d;
      end
   end

   // Round-robin search starting one past the previous grant.
   always_comb begin
      found_c  = 1'b0;
      winner_c = '0;
      cand_c   = '0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         cand_c = ID_W'((32'(last_grant_q) + k) % N_REQ);
         if (!found_c && req[cand_c]) begin
            found_c  = 1'b1;
            winner_c = cand_c;
         end
      end
   end

   // Word of the granted requester, sampled while its gnt is high.
   always_comb begin
      load_word_c = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (ID_W'(i) == last_grant_q) load_word_c = req_data[i*W +: W];
      end
   end

   assign hits_inc_c = (&hits_q) ? hits_q : hits_q + CNT_W'(det_y_c);

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      shreg_d      = shreg_q;
      bit_cnt_d    = bit_cnt_q;
      hits_d       = hits_q;
      gnt_d        = '0;
      done_d       = 1'b0;
      done_id_d    = '0;
      hit_cnt_d    = '0;
      det_in_c     = 1'b0;
      case (state_q)
         IDLE: begin
            if (found_c) begin
               state_d      = LOAD;
               gnt_d        = N_REQ'(1) << winner_c;
               last_grant_d = winner_c;
            end
         end
         LOAD: begin
            state_d   = SHIFT;
            shreg_d   = load_word_c;
            bit_cnt_d = '0;
            hits_d    = '0;
         end
         SHIFT: begin
            det_in_c  = shreg_q[W-1];
            shreg_d   = {shreg_q[W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            hits_d    = hits_inc_c;
            if (bit_cnt_q == BIT_W'(W - 1)) state_d = DRAIN;
         end
         DRAIN: begin
            hits_d    = hits_inc_c;
            state_d   = DONE;
            done_d    = 1'b1;
            done_id_d = last_grant_q;
            hit_cnt_d = hits_inc_c;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   assign det_rst_c = rst | (state_q == LOAD);

   seq1100_det u_det (
      .clk    (clk),
      .rst    (det_rst_c),
      .in_bit (det_in_c),
      .Y      (det_y_c)
   );

   assign gnt     = gnt_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign done_id = done_id_q;
   assign hit_cnt = hit_cnt_q;

`ifdef SEQ_SCHED_STATS_EN
   logic [15:0] total_q, total_d;
   logic [16:0] total_sum_c;

   always_comb begin
      total_d     = total_q;
      total_sum_c = 17'(total_q) + 17'(hit_cnt_q);
      if (state_q == DONE) total_d = total_sum_c[16] ? 16'hFFFF : total_sum_c[15:0];
   end

   always_ff @(posedge clk) begin
      if (rst) total_q <= '0;
      else     total_q <= total_d;
   end

   assign total_hits = total_q;
`endif

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Directed bench for seq_detect_scheduler: vector table plus hold, priority and reset sequences.
module tb_seq_detect_scheduler;

   localparam int unsigned N  = 4;
   localparam int unsigned W  = 8;
   localparam int unsigned CW = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req;
   logic [N*W-1:0]   req_data;
   logic [N-1:0]     gnt;
   logic             busy;
   logic             done;
   logic [1:0]       done_id;
   logic [CW-1:0]    hit_cnt;
`ifdef SEQ_SCHED_STATS_EN
   logic [15:0]      total_hits;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int exp_total = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seq_detect_scheduler #(.N_REQ(N), .W(W), .CNT_W(CW)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_data (req_data),
      .gnt      (gnt),
      .busy     (busy),
      .done     (done),
      .done_id  (done_id),
      .hit_cnt  (hit_cnt)
`ifdef SEQ_SCHED_STATS_EN
      ,
      .total_hits (total_hits)
`endif
   );

   typedef struct {
      logic [N-1:0]   rq;
      logic [N*W-1:0] data;
      logic [N-1:0]   exp_gnt;
      int             exp_id;
      int             exp_hits;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_gnt(output bit ok, output int t);
      ok = 1'b0;
      t  = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (gnt != '0) begin
            ok = 1'b1;
            t  = cyc;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL gnt_timeout: no grant within 40 cycles (cycle %0d)", cyc);
      end
   endtask

   task automatic wait_done(output bit ok, output int t);
      ok = 1'b0;
      t  = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            t  = cyc;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: no done within 40 cycles (cycle %0d)", cyc);
      end
   endtask

   // Runs one job; called just after a falling edge, returns at the falling edge after done.
   task automatic do_job(input logic [N-1:0] rq, input logic [N*W-1:0] dat,
                         input logic [N-1:0] eg, input int eid, input int eh,
                         input bit drop, output int tg);
      bit ok;
      int td;
      req      = rq;
      req_data = dat;
      wait_gnt(ok, tg);
      if (ok) begin
         check("gnt", 32'(gnt), 32'(eg));
         check("busy_load", 32'(busy), 32'd1);
         if (drop) req = req & ~gnt;
         wait_done(ok, td);
         if (ok) begin
            check("latency", 32'(td - tg), 32'(W + 2));
            check("done_id", 32'(done_id), 32'(eid));
            check("hit_cnt", 32'(hit_cnt), 32'(eh));
            check("busy_done", 32'(busy), 32'd1);
            exp_total = (exp_total + eh > 65535) ? 65535 : exp_total + eh;
            @(negedge clk);
            check("done_pulse", 32'(done), 32'd0);
            check("hit_cnt_idle", 32'(hit_cnt), 32'd0);
            check("busy_idle", 32'(busy), 32'd0);
`ifdef SEQ_SCHED_STATS_EN
            check("total_hits", 32'(total_hits), 32'(exp_total));
`endif
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  tg;
      int  prev_tg;
      bit  ok;
      bit  saw_done;

      vecs[0] = '{4'b0001, 32'h000000CC, 4'b0001, 0, 2};
      vecs[1] = '{4'b0001, 32'hCCCCCCE6, 4'b0001, 0, 1};
      vecs[2] = '{4'b0010, 32'hCCCCFFCC, 4'b0010, 1, 0};
      vecs[3] = '{4'b0100, 32'hCC00CCCC, 4'b0100, 2, 0};
      vecs[4] = '{4'b0101, 32'h00CC00CC, 4'b0001, 0, 2};
      vecs[5] = '{4'b0100, 32'hCC3CCCCC, 4'b0100, 2, 1};
      vecs[6] = '{4'b1000, 32'hC3CCCCCC, 4'b1000, 3, 1};
      vecs[7] = '{4'b0001, 32'hCCCCCC4C, 4'b0001, 0, 1};

      rst      = 1'b1;
      req      = '0;
      req_data = '0;
      exp_total = 0;
      repeat (2) @(negedge clk);
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_done_id", 32'(done_id), 32'd0);
      check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
`ifdef SEQ_SCHED_STATS_EN
      check("rst_total_hits", 32'(total_hits), 32'd0);
`endif
      rst = 1'b0;

      for (int v = 0; v < 8; v++) begin
         do_job(vecs[v].rq, vecs[v].data, vecs[v].exp_gnt, vecs[v].exp_id,
                vecs[v].exp_hits, 1'b1, tg);
      end
      req = '0;

      // All requesters held high from reset: strict 0,1,2,3 order, W+4 apart.
      rst       = 1'b1;
      req       = 4'b1111;
      req_data  = 32'hCCCCCCCC;
      exp_total = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      prev_tg = 0;
      for (int j = 0; j < 4; j++) begin
         do_job(4'b1111, 32'hCCCCCCCC, 4'(1 << j), j, 2, 1'b0, tg);
         if (j > 0) check("rr_spacing", 32'(tg - prev_tg), 32'(W + 4));
         prev_tg = tg;
      end
      req = '0;

      // Reset during SHIFT abandons the job; re-request then completes.
      req      = 4'b0010;
      req_data = 32'h0000CC00;
      wait_gnt(ok, tg);
      if (ok) check("abort_gnt", 32'(gnt), 32'b0010);
      req = '0;
      repeat (4) @(negedge clk);
      rst       = 1'b1;
      exp_total = 0;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_gnt_low", 32'(gnt), 32'd0);
      check("abort_done", 32'(done), 32'd0);
`ifdef SEQ_SCHED_STATS_EN
      check("abort_total_hits", 32'(total_hits), 32'd0);
`endif
      saw_done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      check("abort_no_done", 32'(saw_done), 32'd0);
      do_job(4'b0010, 32'h0000CC00, 4'b0010, 1, 2, 1'b1, tg);
      req = '0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
